sd_sector_reader: RTL

//  Sequencer between a host and sdcard_controller: on request, issues one single-block read,

---
 rtl/sd_pkg.sv | 13 +
 rtl/sd_sector_ram.sv | 27 ++
 rtl/sd_sector_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector reader: sector geometry and FSM state encoding.
package sd_pkg;

    localparam int unsigned SD_SECTOR_BYTES = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } sd_state_t;

endpackage

// File: rtl/sd_sector_ram.sv
// Simple dual-port sector buffer: synchronous write, registered read with read enable.
module sd_sector_ram #(
    parameter int unsigned DEPTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Read data holds when rd_en is low so an unconsumed prefetch survives a stall.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sd_sector_reader.sv
// Reads one SD block via the controller byte handshake into a local buffer,
// then replays it to the host as a valid/accept byte stream.
module sd_sector_reader
    import sd_pkg::*;
#(
    parameter int unsigned SECTOR_BYTES = SD_SECTOR_BYTES,
    parameter int unsigned TIMEOUT_CYC  = 2000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_address,
    output logic        o_busy,
    output logic        o_error,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_accept,
    output logic        o_last,
    output logic        o_sd_rd,
    output logic [31:0] o_sd_address,
    input  logic        i_sd_ready,
    input  logic        i_sd_byte_avai,
    input  logic [7:0]  i_sd_data
);

    localparam int unsigned PTR_W = $clog2(SECTOR_BYTES);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SECTOR_BYTES - 1);
    localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(SECTOR_BYTES);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(TIMEOUT_CYC - 1);

    sd_state_t        state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_next;
    logic             avai_q;
    logic             fetch_q, fetch_d;
    logic             fetch_last_q, fetch_last_d;
    logic             busy_d, error_d, valid_d, last_d, sd_rd_d;
    logic [7:0]       data_d;
    logic [31:0]      sd_address_d;
    logic             byte_rise, move, issue;
    logic             ram_we, ram_re;
    logic [7:0]       ram_rdata;

    sd_sector_ram #(
        .DEPTH  (SECTOR_BYTES),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q[PTR_W-1:0]),
        .wr_data (i_sd_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr_q[PTR_W-1:0]),
        .rd_data (ram_rdata)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        tmo_d        = tmo_q;
        fetch_d      = fetch_q;
        fetch_last_d = fetch_last_q;
        busy_d       = o_busy;
        error_d      = o_error;
        data_d       = o_data;
        valid_d      = o_valid;
        last_d       = o_last;
        sd_rd_d      = o_sd_rd;
        sd_address_d = o_sd_address;
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        move         = 1'b0;
        issue        = 1'b0;
        byte_rise    = i_sd_byte_avai && !avai_q;
        tmo_next     = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && i_sd_ready) begin
                    sd_address_d = i_address;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    sd_rd_d      = 1'b1;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    tmo_d        = '0;
                    fetch_d      = 1'b0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_sd_ready) begin
                    sd_rd_d = 1'b0;
                    tmo_d   = tmo_next;
                    state_d = ST_CAPTURE;
                end else if (tmo_q >= TMO_HIT) begin
                    error_d = 1'b1;
                    sd_rd_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            ST_CAPTURE: begin
                if (byte_rise) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    tmo_d    = '0;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                    end
                end else if (tmo_q >= TMO_HIT) begin
                    error_d = 1'b1;
                    sd_rd_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_next;
                end
            end
            ST_DRAIN: begin
                // Prefetch keeps one byte waiting in the RAM output behind the stream register.
                move  = fetch_q && (!o_valid || i_accept);
                issue = (rd_ptr_q != FULL_IDX) && (!fetch_q || move);
                if (o_valid && i_accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (move) begin
                    data_d  = ram_rdata;
                    valid_d = 1'b1;
                    last_d  = fetch_last_q;
                    fetch_d = 1'b0;
                end
                if (issue) begin
                    ram_re       = 1'b1;
                    rd_ptr_d     = rd_ptr_q + CNT_W'(1);
                    fetch_d      = 1'b1;
                    fetch_last_d = (rd_ptr_q == LAST_IDX);
                end
                if (o_valid && i_accept && o_last) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tmo_q        <= '0;
            avai_q       <= 1'b0;
            fetch_q      <= 1'b0;
            fetch_last_q <= 1'b0;
            o_busy       <= 1'b0;
            o_error      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_last       <= 1'b0;
            o_sd_rd      <= 1'b0;
            o_sd_address <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tmo_q        <= tmo_d;
            avai_q       <= i_sd_byte_avai;
            fetch_q      <= fetch_d;
            fetch_last_q <= fetch_last_d;
            o_busy       <= busy_d;
            o_error      <= error_d;
            o_data       <= data_d;
            o_valid      <= valid_d;
            o_last       <= last_d;
            o_sd_rd      <= sd_rd_d;
            o_sd_address <= sd_address_d;
        end
    end

endmodule
